// File: rtl/end_frame_renderer_if.sv
// Pixel request/response channel between the VGA timing generator and the end-frame renderer.
interface end_frame_renderer_if;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic        i_valid;
  logic [23:0] o_rgb;
  logic        o_valid;

  modport master (output i_x, i_y, i_valid, input o_rgb, o_valid);
  modport slave  (input i_x, i_y, i_valid, output o_rgb, o_valid);
endinterface

// File: rtl/end_frame_renderer.sv
// End-of-game still image: palette lookup over a winner-coloured background,
// 2-stage pixel pipeline, vsync-paced fade in/out and blinking palette entries.
//   state       | meaning
//   ST_IDLE     | output black, waiting for i_start
//   ST_FADE_IN  | level rises by one per vsync
//   ST_SHOW     | full brightness, blink timer runs
//   ST_FADE_OUT | level falls by one per vsync, o_done on reaching 0
module end_frame_renderer #(
  parameter int          HORIZONTAL   = 320,
  parameter int          VERTICAL     = 240,
  parameter int          PIXEL_BITS   = 3,
  parameter int          SCALE_SHIFT  = 1,
  parameter int          FADE_BITS    = 3,
  parameter int          BLINK_IDX    = 6,
  parameter int          BLINK_PERIOD = 30,
  parameter logic [23:0] BG_P1        = 24'h0000FF,
  parameter logic [23:0] BG_P2        = 24'hFF0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  end_frame_renderer_if.slave  pix,
  input  logic                 i_vsync_pulse,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_is_p1_win,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int ADDR_W  = $clog2(HORIZONTAL * VERTICAL);
  localparam int LEVEL_W = FADE_BITS + 1;
  localparam int BLINK_W = $clog2(BLINK_PERIOD);
  localparam int PROD_W  = 8 + FADE_BITS + 1;
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(1 << FADE_BITS);

  // Built-in generated art so the block is usable without resource files.
  function automatic logic [PIXEL_BITS-1:0] label_at(input logic [ADDR_W-1:0] addr);
    return PIXEL_BITS'(addr ^ (addr >> 5)) ^ PIXEL_BITS'(5);
  endfunction

  function automatic logic [23:0] colour_at(input logic [PIXEL_BITS-1:0] idx);
    logic [23:0] c;
    case (int'(idx))
      1:       c = 24'hFFFFFF;
      2:       c = 24'h808080;
      4:       c = 24'h4080C0;
      5:       c = 24'hFF8040;
      6:       c = 24'hFFFF00;
      7:       c = 24'h00FF00;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] fade_ch(input logic [7:0] ch, input logic [LEVEL_W-1:0] lv);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(ch) * PROD_W'(lv);
    return 8'(prod >> FADE_BITS);
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_FADE_IN, ST_SHOW, ST_FADE_OUT} state_t;

  state_t               state, state_n;
  logic [LEVEL_W-1:0]   level, level_n;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_n;
  logic                 blink_phase, blink_phase_n;
  logic                 winner, winner_n;
  logic                 done_n;

  logic [9:0]            sx;
  logic [8:0]            sy;
  logic [ADDR_W-1:0]     addr;
  logic [PIXEL_BITS-1:0] idx_lookup, idx_s1;
  logic                  valid_s1;
  logic [23:0]           base, faded;

  always_comb begin
    sx         = pix.i_x >> SCALE_SHIFT;
    sy         = pix.i_y >> SCALE_SHIFT;
    addr       = ADDR_W'(32'(sy) * 32'(HORIZONTAL) + 32'(sx));
    idx_lookup = '0;
    if (int'(sx) < HORIZONTAL && int'(sy) < VERTICAL)
      idx_lookup = label_at(addr);
  end

  // Transparent entries (index 0, black palette slot, blinked-off) show the winner colour.
  always_comb begin
    base = colour_at(idx_s1);
    if (idx_s1 == '0 || base == 24'h0 || (blink_phase && int'(idx_s1) >= BLINK_IDX))
      base = winner ? BG_P1 : BG_P2;
    faded = {fade_ch(base[23:16], level), fade_ch(base[15:8], level), fade_ch(base[7:0], level)};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_s1    <= 1'b0;
      idx_s1      <= '0;
      pix.o_valid <= 1'b0;
      pix.o_rgb   <= 24'h0;
    end else begin
      valid_s1    <= pix.i_valid;
      if (pix.i_valid) idx_s1 <= idx_lookup;
      pix.o_valid <= valid_s1;
      if (valid_s1) pix.o_rgb <= faded;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      level       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      winner      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
      winner      <= winner_n;
      o_done      <= done_n;
    end
  end

  // A stop arriving with vsync takes the transition and skips that frame's level/blink step.
  always_comb begin
    state_n       = state;
    level_n       = level;
    blink_cnt_n   = blink_cnt;
    blink_phase_n = blink_phase;
    winner_n      = winner;
    done_n        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_n  = ST_FADE_IN;
          winner_n = i_is_p1_win;
          level_n  = '0;
        end
      end
      ST_FADE_IN: begin
        if (i_stop) begin
          state_n = ST_FADE_OUT;
        end else if (i_vsync_pulse) begin
          level_n = level + 1'b1;
          if (level_n == FULL_LEVEL) begin
            state_n       = ST_SHOW;
            blink_cnt_n   = '0;
            blink_phase_n = 1'b0;
          end
        end
      end
      ST_SHOW: begin
        if (i_stop) begin
          state_n = ST_FADE_OUT;
        end else if (i_vsync_pulse) begin
          if (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
            blink_cnt_n   = '0;
            blink_phase_n = ~blink_phase;
          end else begin
            blink_cnt_n = blink_cnt + 1'b1;
          end
        end
      end
      ST_FADE_OUT: begin
        if (i_vsync_pulse) begin
          if (level <= LEVEL_W'(1)) begin
            level_n       = '0;
            state_n       = ST_IDLE;
            done_n        = 1'b1;
            blink_phase_n = 1'b0;
          end else begin
            level_n = level - 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_busy = (state != ST_IDLE);
endmodule

// File: tb/tb_end_frame_renderer.sv
// Bench for end_frame_renderer: scenario tasks with a queue of expected pixel colours.
module tb_end_frame_renderer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b0, start = 1'b0, stop = 1'b0, p1_win = 1'b0;
  logic busy, done;
  int   checks = 0;
  int   failures = 0;
  logic [23:0] sb [$];
  int   m_lvl = 0;
  logic m_phase = 1'b0;
  logic m_win = 1'b0;
  logic [23:0] pal [8] = '{24'h000000, 24'hFFFFFF, 24'h808080, 24'h000000,
                           24'h4080C0, 24'hFF8040, 24'hFFFF00, 24'h00FF00};

  end_frame_renderer_if pif();

  end_frame_renderer dut (
    .i_clk(clk), .i_rst_n(rst_n), .pix(pif.slave),
    .i_vsync_pulse(vsync), .i_start(start), .i_stop(stop), .i_is_p1_win(p1_win),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_pix(input int x, input int y);
    int sx, sy, addr, idx;
    logic [23:0] c;
    sx  = x >> 1;
    sy  = y >> 1;
    idx = 0;
    if (sx < 320 && sy < 240) begin
      addr = sy * 320 + sx;
      idx  = ((addr ^ (addr >> 5)) & 7) ^ 5;
    end
    c = pal[idx];
    if (idx == 0 || c == 24'h0 || (m_phase && idx >= 6)) c = m_win ? 24'h0000FF : 24'hFF0000;
    return {8'((int'(c[23:16]) * m_lvl) >> 3), 8'((int'(c[15:8]) * m_lvl) >> 3),
            8'((int'(c[7:0]) * m_lvl) >> 3)};
  endfunction

  task automatic vsync_with(input logic st, input logic sp);
    @(negedge clk); vsync = 1'b1; start = st; stop = sp;
    @(negedge clk); vsync = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic start_pulse(input logic win);
    @(negedge clk); start = 1'b1; p1_win = win;
    @(negedge clk); start = 1'b0;
    m_win = win; m_lvl = 0; m_phase = 1'b0;
  endtask

  task automatic req(input int x, input int y, input logic [23:0] exp, input string tag);
    logic [23:0] want;
    @(negedge clk);
    pif.i_valid = 1'b1; pif.i_x = 10'(x); pif.i_y = 9'(y);
    sb.push_back(exp);
    @(negedge clk); pif.i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pif.o_valid !== 1'b1 || sb.size() == 0) begin
      failures++;
      $display("FAIL %s_valid got=%b exp=1", tag, pif.o_valid);
      sb.delete();
    end else begin
      want = sb.pop_front();
      if (pif.o_rgb !== want) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", tag, pif.o_rgb, want);
      end
    end
  endtask

  task automatic run_to_idle();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) vsync_with(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL run_to_idle_timeout got=%b exp=0", busy); end
    m_lvl = 0; m_phase = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (pif.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pif.o_valid); end
    checks++; if (pif.o_rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=000000", pif.o_rgb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    req(0, 0, 24'h000000, "idle_black");
  endtask

  task automatic test_fade_in();
    p1_win = 1'b1;
    vsync_with(1'b1, 1'b0);
    m_win = 1'b1; m_lvl = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fadein_busy got=%b exp=1", busy); end
    req(0, 0, 24'h000000, "fadein_lvl0");
    for (int k = 1; k <= 8; k++) begin
      vsync_with(1'b0, 1'b0);
      m_lvl = k;
      req(0, 0, (k == 4) ? 24'h7F4020 : ((k == 8) ? 24'hFF8040 : model_pix(0, 0)), "fadein_ramp");
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL show_busy got=%b exp=1", busy); end
  endtask

  task automatic test_background();
    req(640, 0, 24'h0000FF, "bg_out_of_range_x");
    req(0, 480, 24'h0000FF, "bg_out_of_range_y");
    req(10, 0, 24'h0000FF, "bg_index0");
    req(12, 0, 24'h0000FF, "bg_black_palette");
    req(4, 0, 24'h00FF00, "idx7_row0");
    req(0, 2, 24'h00FF00, "idx7_row1");
  endtask

  task automatic test_blink();
    for (int p = 0; p <= 61; p++) begin
      if (p > 0) vsync_with(1'b0, 1'b0);
      m_phase = ((p / 30) % 2) == 1;
      req(4, 0, m_phase ? 24'h0000FF : 24'h00FF00, "blink");
      if (p == 30) req(0, 0, 24'hFF8040, "blink_non_blinking");
    end
    vsync_with(1'b0, 1'b1);
    req(0, 0, 24'hFF8040, "stop_vsync_show_level");
    for (int k = 7; k >= 0; k--) begin
      vsync_with(1'b0, 1'b0);
      m_lvl = k;
      checks++; if (done !== (k == 0)) begin failures++; $display("FAIL fadeout_done got=%b exp=%b", done, k == 0); end
      checks++; if (busy !== (k != 0)) begin failures++; $display("FAIL fadeout_busy got=%b exp=%b", busy, k != 0); end
      if (k > 0) req(0, 0, model_pix(0, 0), "fadeout_ramp");
    end
    m_phase = 1'b0;
  endtask

  task automatic test_winner_p2();
    start_pulse(1'b0);
    for (int k = 1; k <= 8; k++) begin vsync_with(1'b0, 1'b0); m_lvl = k; end
    req(640, 0, 24'hFF0000, "p2_out_of_range");
    req(10, 0, 24'hFF0000, "p2_index0");
  endtask

  task automatic test_back_to_back();
    logic vin [100];
    logic exp_v;
    logic [23:0] want;
    int x, y;
    for (int i = 0; i < 100; i++) vin[i] = (i != 50);
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      exp_v = (i >= 2) ? vin[i-2] : 1'b0;
      checks++;
      if (pif.o_valid !== exp_v) begin
        failures++;
        $display("FAIL b2b_valid cycle=%0d got=%b exp=%b", i, pif.o_valid, exp_v);
      end
      if (pif.o_valid === 1'b1 && sb.size() != 0) begin
        want = sb.pop_front();
        checks++;
        if (pif.o_rgb !== want) begin
          failures++;
          $display("FAIL b2b_rgb cycle=%0d got=%h exp=%h", i, pif.o_rgb, want);
        end
      end
      if (i < 100) begin
        x = (i * 2) % 40; y = (i / 40) * 2;
        pif.i_valid = vin[i]; pif.i_x = 10'(x); pif.i_y = 9'(y);
        if (vin[i]) sb.push_back(model_pix(x, y));
      end else begin
        pif.i_valid = 1'b0;
      end
    end
    run_to_idle();
  endtask

  task automatic test_stop_fade_in();
    start_pulse(1'b1);
    for (int k = 1; k <= 5; k++) begin vsync_with(1'b0, 1'b0); m_lvl = k; end
    vsync_with(1'b0, 1'b1);
    req(0, 0, 24'h9F5028, "stop_vsync_fadein_level");
    @(negedge clk); start = 1'b1; p1_win = 1'b0;
    @(negedge clk); start = 1'b0;
    req(10, 0, 24'h00009F, "winner_stable");
    for (int k = 4; k >= 0; k--) begin
      vsync_with(1'b0, 1'b0);
      m_lvl = k;
      checks++; if (done !== (k == 0)) begin failures++; $display("FAIL stop_done got=%b exp=%b", done, k == 0); end
      checks++; if (busy !== (k != 0)) begin failures++; $display("FAIL stop_busy got=%b exp=%b", busy, k != 0); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done); end
    req(0, 0, 24'h000000, "after_done_black");
  endtask

  task automatic test_reset_mid();
    logic [23:0] want;
    start_pulse(1'b1);
    for (int k = 1; k <= 8; k++) begin vsync_with(1'b0, 1'b0); m_lvl = k; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pif.i_valid = 1'b1; pif.i_x = 10'd0; pif.i_y = 9'd0;
      sb.push_back(24'hFF8040);
    end
    checks++;
    if (pif.o_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL pre_reset_valid got=%b exp=1", pif.o_valid);
    end else begin
      want = sb.pop_front();
      if (pif.o_rgb !== want) begin failures++; $display("FAIL pre_reset_rgb got=%h exp=%h", pif.o_rgb, want); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pif.o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", pif.o_valid); end
    checks++; if (pif.o_rgb !== 24'h0) begin failures++; $display("FAIL midrst_rgb got=%h exp=000000", pif.o_rgb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    sb.delete();
    pif.i_valid = 1'b0;
    m_lvl = 0; m_win = 1'b0; m_phase = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); pif.i_valid = 1'b1; pif.i_x = 10'd0; pif.i_y = 9'd0; sb.push_back(24'h000000);
    @(negedge clk); pif.i_valid = 1'b0;
    checks++; if (pif.o_valid !== 1'b0) begin failures++; $display("FAIL post_rst_early got=%b exp=0", pif.o_valid); end
    @(negedge clk);
    checks++;
    if (pif.o_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL post_rst_valid got=%b exp=1", pif.o_valid);
    end else begin
      want = sb.pop_front();
      if (pif.o_rgb !== want) begin failures++; $display("FAIL post_rst_rgb got=%h exp=%h", pif.o_rgb, want); end
    end
    @(negedge clk);
  endtask

  initial begin
    pif.i_valid = 1'b0; pif.i_x = '0; pif.i_y = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_fade_in();
    test_background();
    test_blink();
    test_winner_p2();
    test_back_to_back();
    test_stop_fade_in();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/end_frame_renderer.md
Name: end_frame_renderer

Overview:
- Parametrised successor to the end-of-game frame ROM.
- Renders a palette-indexed, integer-upscaled still image over a winner-coloured background, through a registered 2-stage pixel pipeline.
- Adds a vsync-paced fade-in/fade-out state machine and blinking of selected palette entries.
- Sits between the VGA timing generator and the top-level RGB mux.

Parameters:
- HORIZONTAL, 320, source image width in source pixels
- VERTICAL, 240, source image height in source pixels
- PIXEL_BITS, 3, palette index width; palette depth is 2^PIXEL_BITS
- SCALE_SHIFT, 1, screen-to-source downscale: source coord = screen coord >> SCALE_SHIFT
- FADE_BITS, 3, fade resolution; full brightness level is 2^FADE_BITS
- BLINK_IDX, 6, palette indices >= this value blink in SHOW
- BLINK_PERIOD, 30, vsync pulses per blink half-period
- BG_P1, 24'h0000FF, background colour when player 1 wins
- BG_P2, 24'hFF0000, background colour when player 2 wins
- LABEL_FILE / PALETTE_FILE, "resource/dat/victory_labels.dat" / "resource/dat/victory_values.dat", $readmemh sources, loaded only under `COMPILE_FRAME

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_x  in  10  screen x of requested pixel
- i_y  in  9  screen y of requested pixel
- i_valid  in  1  pixel request valid this cycle
- i_vsync_pulse  in  1  one-cycle pulse per frame, at frame start
- i_start  in  1  begin fade-in; sampled in IDLE only
- i_stop  in  1  begin fade-out; sampled in FADE_IN/SHOW
- i_is_p1_win  in  1  winner select, latched on accepted i_start
- o_rgb  out  24  pixel colour, valid when o_valid
- o_valid  out  1  i_valid delayed 2 cycles
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse on FADE_OUT -> IDLE

Behaviour:
- Reset, asynchronous:
  - state IDLE, level 0, blink_cnt 0, blink_phase 0, winner 0
  - both pipeline valids 0; o_rgb 24'h0, o_valid 0, o_done 0
  - Reset mid-operation drops in-flight pixels with no partial output.
- Stage 1, on i_valid:
  - sx = i_x >> SCALE_SHIFT, sy = i_y >> SCALE_SHIFT
  - if sx >= HORIZONTAL or sy >= VERTICAL: registered index forced to 0, else index = mem[sy*HORIZONTAL+sx]
  - address width = $clog2(HORIZONTAL*VERTICAL)
- Stage 2, base colour:
  - base = palette[index], with background substitution when index == 0, or when palette[index] == 24'h0, or when (blink_phase && index >= BLINK_IDX)
  - background = winner ? BG_P1 : BG_P2
- Stage 2, fade:
  - each 8-bit channel out = (ch * level) >> FADE_BITS, with level in 0..2^FADE_BITS and product width 8+FADE_BITS+1
  - level == 2^FADE_BITS passes colour unchanged
  - result registered to o_rgb
- Total latency is 2 cycles; back-to-back requests are accepted every cycle.
- o_rgb holds its last value when o_valid == 0.
- State machine; level and blink change only on i_vsync_pulse, so no tearing within a frame:
  - IDLE: level 0, so output is black. i_start -> FADE_IN, latches winner.
  - FADE_IN: each vsync level += 1. After the increment reaching 2^FADE_BITS -> SHOW, with blink_cnt = 0 and blink_phase = 0. i_stop -> FADE_OUT at current level. i_start ignored.
  - SHOW: each vsync blink_cnt += 1; at BLINK_PERIOD-1 it wraps to 0 and blink_phase toggles. i_stop -> FADE_OUT.
  - FADE_OUT: each vsync level -= 1. After the decrement reaching 0 -> IDLE, o_done pulses on that cycle, blink_phase cleared. i_start and i_stop ignored.
- Simultaneous events:
  - i_stop with i_vsync_pulse in FADE_IN: the transition wins and the level is not incremented that cycle.
  - i_stop with i_vsync_pulse in SHOW: the transition wins and blink is not advanced.
  - i_start with i_vsync_pulse in IDLE: enter FADE_IN with level 0; the first increment comes on the next pulse.
- winner is stable from i_start until the return to IDLE.

Test Plan (defaults; palette[5] = 24'hFF8040, palette[7] = 24'h00FF00, mem[0] = 5):
- Reset asserted mid-SHOW with requests in flight -> o_valid = 0, o_rgb = 0, o_busy = 0 immediately; after release, i_valid at (0,0) gives o_rgb = 0 two cycles later.
- i_start with i_is_p1_win = 1, then 8 vsync pulses -> level 1..8; at level 4, pixel (0,0) = 24'h7F4020; after pulse 8, o_busy = 1 and pixel = 24'hFF8040.
- Pixel requests at x = 640, y = 0 and at an index-0 location, in SHOW -> o_rgb = BG_P1 = 24'h0000FF; with i_is_p1_win = 0 at start -> 24'hFF0000.
- SHOW with an index-7 pixel streamed -> 24'h00FF00 for pulses 0-29, BG_P1 for pulses 30-59, 24'h00FF00 again from pulse 60.
- i_stop at level 5 during FADE_IN -> FADE_OUT; 5 pulses later o_done is high for exactly 1 cycle, o_busy = 0, and further pixels are 24'h0.
- Continuous i_valid for 100 cycles with an i_valid gap at cycle 50 -> o_valid equals i_valid shifted by exactly 2 cycles, including the gap.
